muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit for the EX stage. It replaces the single-cycle signed/unsigned multiplier with a WIDTH-cycle shift-add multiplier and restoring divider, and adds DIV/DIVU, MADD/MADDU and MSUB/MSUBU. The EX stage holds the pipeline on `busy_o`. The unit returns a HI/LO write packet (`hi_o`, `lo_o`, `whilo_o`) toward MEM/WB.

---
 rtl/muldiv_pkg.sv | 39 +++
 rtl/muldiv_negate.sv | 12 +
 rtl/muldiv_unit.sv | 188 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: operation encoding,
// FSM states and small operation-class predicates.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MADDU = 3'd5,
    OP_MSUB  = 3'd6,
    OP_MSUBU = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_madd(input op_e op);
    return (op == OP_MADD) || (op == OP_MADDU);
  endfunction

  function automatic logic is_msub(input op_e op);
    return (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's complement: dout = neg ? -din : din.
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: WIDTH-cycle shift-add multiplier and
// restoring divider with MADD/MSUB accumulation into a HI/LO write packet.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic             cancel_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             whilo_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  // Handshake: a request (start_i) is taken on a rising edge only when the
  // unit is IDLE or DONE and cancel_i is low; busy_o is the not-ready
  // indication, and done_o/whilo_o form a one-cycle valid with no back-pressure.

  state_e               state, state_n;
  op_e                  op_in, op_q;
  logic                 accept;
  logic                 sign_in, sign_q;
  logic                 sa_q, sb_q, dz_q;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH-1:0]     opnd_q, raw_a_q;
  logic [2*WIDTH-1:0]   hilo_q, acc_q;
  logic [WIDTH:0]       rem_q;
  logic [CW-1:0]        cnt_q;

  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift, div_rem_next;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_quo_next;

  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;
  logic [2*WIDTH-1:0]   result;

  assign op_in   = op_e'(op_i);
  assign sign_in = is_signed(op_in);

  muldiv_negate #(.W(WIDTH)) u_neg_a (
    .neg  (sign_in & a_i[WIDTH-1]),
    .din  (a_i),
    .dout (mag_a)
  );

  muldiv_negate #(.W(WIDTH)) u_neg_b (
    .neg  (sign_in & b_i[WIDTH-1]),
    .din  (b_i),
    .dout (mag_b)
  );

  // ---------------- FSM ----------------
  assign accept = start_i && !cancel_i && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state)
      IDLE: if (accept) state_n = CALC;
      CALC: begin
        busy_o = 1'b1;
        if (cnt_q == CW'(1)) state_n = FIX;
      end
      FIX: begin
        busy_o  = 1'b1;
        state_n = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_n = accept ? CALC : IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (cancel_i) state_n = IDLE;
  end

  assign whilo_o   = done_o;
  assign dbg_state = state;

  // ---------------- iteration steps ----------------
  // Multiply: acc holds {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                    (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc[WIDTH-1:0] shifts dividend bits out and quotient bits in.
  assign div_shift    = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
  assign div_ge       = div_shift >= {1'b0, opnd_q};
  assign div_rem_next = div_ge ? (div_shift - {1'b0, opnd_q}) : div_shift;
  assign div_quo_next = {acc_q[WIDTH-2:0], div_ge};

  // ---------------- sign fix and accumulate ----------------
  muldiv_negate #(.W(2*WIDTH)) u_neg_prod (
    .neg  (sign_q & (sa_q ^ sb_q)),
    .din  (acc_q),
    .dout (prod_fix)
  );

  muldiv_negate #(.W(WIDTH)) u_neg_quo (
    .neg  (sign_q & (sa_q ^ sb_q)),
    .din  (acc_q[WIDTH-1:0]),
    .dout (quo_fix)
  );

  muldiv_negate #(.W(WIDTH)) u_neg_rem (
    .neg  (sign_q & sa_q),
    .din  (rem_q[WIDTH-1:0]),
    .dout (rem_fix)
  );

  always_comb begin
    result = prod_fix;
    if (is_div(op_q)) begin
      // Divide by zero reports the untouched dividend, not its magnitude.
      if (dz_q) result = {raw_a_q, {WIDTH{1'b1}}};
      else      result = {rem_fix, quo_fix};
    end else if (is_madd(op_q)) begin
      result = hilo_q + prod_fix;
    end else if (is_msub(op_q)) begin
      result = hilo_q - prod_fix;
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= OP_MULT;
      sign_q  <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      opnd_q  <= '0;
      raw_a_q <= '0;
      hilo_q  <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      hi_o    <= '0;
      lo_o    <= '0;
    end else if (accept) begin
      op_q    <= op_in;
      sign_q  <= sign_in;
      sa_q    <= a_i[WIDTH-1];
      sb_q    <= b_i[WIDTH-1];
      dz_q    <= (b_i == '0);
      raw_a_q <= a_i;
      hilo_q  <= {hi_i, lo_i};
      opnd_q  <= is_div(op_in) ? mag_b : mag_a;
      acc_q   <= is_div(op_in) ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
      rem_q   <= '0;
      cnt_q   <= CW'(WIDTH);
    end else if (cancel_i) begin
      cnt_q <= '0;
    end else if (state == CALC) begin
      cnt_q <= cnt_q - CW'(1);
      if (is_div(op_q)) begin
        acc_q <= {acc_q[2*WIDTH-1:WIDTH], div_quo_next};
        rem_q <= div_rem_next;
      end else begin
        acc_q <= mul_next;
      end
    end else if (state == FIX) begin
      {hi_o, lo_o} <= result;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomised checks of muldiv_unit: results, latency, busy
// window, cancel/reset abort and back-to-back acceptance.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst, start_i, cancel_i;
  logic [2:0]    op_i;
  logic [W-1:0]  a_i, b_i, hi_i, lo_i;
  logic          busy_o, done_o, whilo_o;
  logic [W-1:0]  hi_o, lo_o;
  logic [1:0]    dbg_state;

  int            checks = 0;
  int            errors = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_res;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .op_i      (op_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .hi_i      (hi_i),
    .lo_i      (lo_i),
    .cancel_i  (cancel_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .whilo_o   (whilo_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input op_e op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    r = '0;
    case (op)
      OP_MULTU: r = {32'b0, a} * {32'b0, b};
      OP_MULT:  r = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
      OP_DIVU:  r = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default:  r = '0;
    endcase
    return r;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_start(input op_e op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] hi, input logic [31:0] lo);
    op_i    = op;
    a_i     = a;
    b_i     = b;
    hi_i    = hi;
    lo_i    = lo;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  // Runs one operation and returns in its DONE cycle, so a following call
  // exercises back-to-back acceptance.
  task automatic run_op(input string tag, input op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                        input logic [63:0] exp);
    int n;
    int busy_n;
    logic [63:0] want;
    exp_q.push_back(exp);
    drive_start(op, a, b, hi, lo);
    check({tag, " busy_after_accept"}, 64'(busy_o), 64'd1);
    n = 0;
    busy_n = 0;
    while (done_o !== 1'b1 && n < 200) begin
      if (busy_o === 1'b1) busy_n++;
      @(posedge clk);
      #1;
      n++;
    end
    // n+1 counts the accept edge as well.
    check({tag, " latency_edges"}, 64'(n + 1), 64'(W + 2));
    check({tag, " busy_cycles"}, 64'(busy_n), 64'(W + 1));
    check({tag, " whilo"}, 64'(whilo_o), 64'd1);
    want = exp_q.pop_front();
    check({tag, " result"}, {hi_o, lo_o}, want);
    last_res = want;
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk);
    #1;
    check({tag, " done_one_cycle"}, 64'(done_o), 64'd0);
    check({tag, " result_held"}, {hi_o, lo_o}, last_res);
  endtask

  task automatic watch_no_done(input string tag);
    int dn;
    dn = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done_o === 1'b1) dn++;
    end
    check({tag, " no_done"}, 64'(dn), 64'd0);
    check({tag, " result_kept"}, {hi_o, lo_o}, last_res);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] ra, rb;
    rst = 1'b1; start_i = 1'b0; cancel_i = 1'b0;
    op_i = '0; a_i = '0; b_i = '0; hi_i = '0; lo_i = '0;
    last_res = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("reset busy", 64'(busy_o), 64'd0);
    check("reset done", 64'(done_o), 64'd0);
    check("reset whilo", 64'(whilo_o), 64'd0);
    check("reset hilo", {hi_o, lo_o}, 64'd0);
    check("reset state", 64'(dbg_state), 64'(IDLE));

    run_op("mult_neg3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, '0, '0, 64'hFFFF_FFFF_FFFF_FFF1);
    idle_check("mult_neg3x5");
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, '0, '0, {32'd2, 32'd14});
    idle_check("divu_100_7");
    run_op("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, '0, '0, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    idle_check("div_neg7_2");
    run_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, '0, '0, {32'd0, 32'h8000_0000});
    idle_check("div_min_m1");
    run_op("divu_by0", OP_DIVU, 32'd5, 32'd0, '0, '0, {32'd5, 32'hFFFF_FFFF});
    idle_check("divu_by0");
    run_op("div_neg5_by0", OP_DIV, 32'hFFFF_FFFB, 32'd0, '0, '0, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
    idle_check("div_neg5_by0");
    run_op("maddu_carry", OP_MADDU, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, {32'd1, 32'd0});
    idle_check("maddu_carry");
    run_op("msub_wrap", OP_MSUB, 32'd1, 32'd1, 32'd0, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    idle_check("msub_wrap");
    run_op("madd_negprod", OP_MADD, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd10, {32'd0, 32'd4});
    idle_check("madd_negprod");
    run_op("msubu_borrow", OP_MSUBU, 32'd2, 32'd3, 32'd1, 32'd0, {32'd0, 32'hFFFF_FFFA});
    idle_check("msubu_borrow");

    // Cancel in the tenth CALC cycle.
    drive_start(OP_MULT, 32'd7, 32'd9, '0, '0);
    repeat (9) @(posedge clk);
    #1;
    cancel_i = 1'b1;
    @(posedge clk);
    #1;
    cancel_i = 1'b0;
    check("cancel busy", 64'(busy_o), 64'd0);
    check("cancel state", 64'(dbg_state), 64'(IDLE));
    watch_no_done("cancel");
    run_op("multu_max_after_cancel", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, '0,
           {32'hFFFF_FFFE, 32'd1});
    idle_check("multu_max_after_cancel");

    // Reset in the tenth CALC cycle clears the result registers.
    drive_start(OP_DIVU, 32'd1000, 32'd3, '0, '0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_res = '0;
    check("midrst busy", 64'(busy_o), 64'd0);
    check("midrst hilo", {hi_o, lo_o}, 64'd0);
    watch_no_done("midrst");
    run_op("multu_max_after_rst", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, '0,
           {32'hFFFF_FFFE, 32'd1});
    idle_check("multu_max_after_rst");

    // Cancel together with start drops the request.
    op_i = OP_MULTU; a_i = 32'd3; b_i = 32'd4;
    start_i = 1'b1;
    cancel_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    cancel_i = 1'b0;
    check("cancel_start busy", 64'(busy_o), 64'd0);
    check("cancel_start state", 64'(dbg_state), 64'(IDLE));
    watch_no_done("cancel_start");

    // Back-to-back: each call starts in the previous DONE cycle.
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      case (i % 3)
        0: run_op("b2b_multu", OP_MULTU, ra, rb, '0, '0, model(OP_MULTU, ra, rb));
        1: run_op("b2b_mult", OP_MULT, ra, rb, '0, '0, model(OP_MULT, ra, rb));
        default: begin
          rb = 32'($urandom_range(1, 5000));
          run_op("b2b_divu", OP_DIVU, ra, rb, '0, '0, model(OP_DIVU, ra, rb));
        end
      endcase
    end
    idle_check("b2b_tail");

    check("scoreboard empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
